// File: rtl/regfile_arb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
//   Shared types and helpers for the register-file write-port arbiter.
//   - addr_width(): register address width for a given register count
//   - wr_req_t    : one register write request {rd, data}, sized for the
//                   default 32 x 32-bit configuration
//   - port_sel_t  : which source owns the write port in a given cycle
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int AW_DEF = addr_width(DEPTH_DEF);

    typedef struct packed {
        logic [AW_DEF-1:0]    rd;
        logic [WIDTH_DEF-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_WB,
        SEL_LLU
    } port_sel_t;

endpackage

// File: rtl/llu_result_fifo.sv
// -----------------------------------------------------------------------------
// llu_result_fifo
//   Small FIFO holding long-latency-unit results until the write port is free.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     in_valid / in_ready  enqueue handshake (in_ready = not full)
//     in_rd, in_data       destination register and result to enqueue
//     head_valid           FIFO non-empty
//     head_rd, head_data   oldest entry
//     pop                  dequeue the head this cycle (ignored when empty)
// -----------------------------------------------------------------------------
module llu_result_fifo #(
    parameter int QDEPTH = 2,
    parameter int WIDTH  = 32,
    parameter int AW     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_rd,
    input  logic [WIDTH-1:0] in_data,
    output logic             head_valid,
    output logic [AW-1:0]    head_rd,
    output logic [WIDTH-1:0] head_data,
    input  logic             pop
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [AW-1:0]    rd_mem   [QDEPTH];
    logic [WIDTH-1:0] data_mem [QDEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             do_pop;

    assign in_ready   = (count != CW'(QDEPTH));
    assign head_valid = (count != '0);
    assign push       = in_valid && in_ready;
    assign do_pop     = pop && head_valid;
    assign head_rd    = rd_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];

    // NOTE: storage has no reset; an entry is only observable once count says
    // it was written, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= in_rd;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // QDEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//   Shares the register file's single write port between the pipeline WB stage
//   (priority) and queued long-latency-unit results, and tracks destinations
//   of in-flight LLU ops so decode can stall on RAW/WAW hazards.
//   Ports:
//     clk, rst                    clock, asynchronous active-high reset
//     wb_valid, wb_rd, wb_data    WB result (always accepted)
//     llu_valid/llu_ready,
//     llu_rd, llu_data            LLU result enqueue handshake
//     issue_valid, issue_rd       LLU op issued; marks rd pending
//     dec_rs1, dec_rs2, dec_rd    decode operands checked against pending
//     hazard_stall                decode must stall (combinational)
//     drain_req                   upstream must hold wb_valid=0 next cycle
//     REGWRITE, ADR_WR_REG,
//     WR_DATA                     registered register-file write port
// -----------------------------------------------------------------------------
module regfile_wr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int  WIDTH      = 32,
    parameter int  DEPTH      = 32,
    parameter int  QDEPTH     = 2,
    parameter int  STARVE_MAX = 4,
    localparam int AW         = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             llu_valid,
    output logic             llu_ready,
    input  logic [AW-1:0]    llu_rd,
    input  logic [WIDTH-1:0] llu_data,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic [AW-1:0]    dec_rs1,
    input  logic [AW-1:0]    dec_rs2,
    input  logic [AW-1:0]    dec_rd,
    output logic             hazard_stall,
    output logic             drain_req,
    output logic             REGWRITE,
    output logic [AW-1:0]    ADR_WR_REG,
    output logic [WIDTH-1:0] WR_DATA
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic             fifo_valid;
    logic [AW-1:0]    head_rd;
    logic [WIDTH-1:0] head_data;
    logic             pop;
    logic             wb_write;
    port_sel_t        sel;
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_next;
    logic [SW-1:0]    starve_cnt;
    logic [SW-1:0]    starve_next;

    llu_result_fifo #(
        .QDEPTH (QDEPTH),
        .WIDTH  (WIDTH),
        .AW     (AW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (llu_valid),
        .in_ready   (llu_ready),
        .in_rd      (llu_rd),
        .in_data    (llu_data),
        .head_valid (fifo_valid),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .pop        (pop)
    );

    // A WB result targeting x0 is a no-op and must not block a FIFO drain.
    assign wb_write = wb_valid && (wb_rd != '0);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        sel = SEL_NONE;
        if (wb_write)        sel = SEL_WB;
        else if (fifo_valid) sel = SEL_LLU;
    end

    // An x0 entry still gets popped; it just produces no write.
    assign pop = (sel == SEL_LLU);

    // Clear before set so a same-cycle re-issue of the draining rd stays pending.
    always_comb begin
        pending_next = pending;
        if (pop && (head_rd != '0))            pending_next[head_rd]  = 1'b0;
        if (issue_valid && (issue_rd != '0))   pending_next[issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // Counts cycles the FIFO waits behind WB; an empty FIFO or a drain resets it.
    always_comb begin
        starve_next = starve_cnt;
        if (!fifo_valid || pop)
            starve_next = '0;
        else if ((sel == SEL_WB) && (starve_cnt != SW'(STARVE_MAX)))
            starve_next = starve_cnt + 1'b1;
    end

    assign hazard_stall = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd];

    // Address/data hold their last value on idle cycles; only REGWRITE drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            REGWRITE   <= 1'b0;
            ADR_WR_REG <= '0;
            WR_DATA    <= '0;
            drain_req  <= 1'b0;
            pending    <= '0;
            starve_cnt <= '0;
        end else begin
            pending    <= pending_next;
            starve_cnt <= starve_next;
            drain_req  <= (starve_next == SW'(STARVE_MAX));
            REGWRITE   <= 1'b0;
            case (sel)
                SEL_WB: begin
                    REGWRITE   <= 1'b1;
                    ADR_WR_REG <= wb_rd;
                    WR_DATA    <= wb_data;
                end
                SEL_LLU: begin
                    if (head_rd != '0) begin
                        REGWRITE   <= 1'b1;
                        ADR_WR_REG <= head_rd;
                        WR_DATA    <= head_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Decode should have stalled any op whose destination is still in flight.
    a_no_reissue_pending: assert property (
        @(posedge clk) disable iff (rst)
        (issue_valid && (issue_rd != '0)) |-> !pending[issue_rd]
    ) else $error("LLU issue to already-pending rd");

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
    import regfile_arb_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             llu_valid;
    logic             llu_ready;
    logic [AW-1:0]    llu_rd;
    logic [WIDTH-1:0] llu_data;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic [AW-1:0]    dec_rs1;
    logic [AW-1:0]    dec_rs2;
    logic [AW-1:0]    dec_rd;
    logic             hazard_stall;
    logic             drain_req;
    logic             REGWRITE;
    logic [AW-1:0]    ADR_WR_REG;
    logic [WIDTH-1:0] WR_DATA;

    logic [WIDTH-1:0] bank [DEPTH];

    int tests_run    = 0;
    int tests_failed = 0;

    regfile_wr_arbiter #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .QDEPTH     (2),
        .STARVE_MAX (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .llu_valid    (llu_valid),
        .llu_ready    (llu_ready),
        .llu_rd       (llu_rd),
        .llu_data     (llu_data),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .hazard_stall (hazard_stall),
        .drain_req    (drain_req),
        .REGWRITE     (REGWRITE),
        .ADR_WR_REG   (ADR_WR_REG),
        .WR_DATA      (WR_DATA)
    );

    always #5 clk = ~clk;

    // Register bank model: samples the write port on the falling edge.
    always @(negedge clk) begin
        if (REGWRITE) bank[ADR_WR_REG] <= WR_DATA;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic v, input logic [AW-1:0] rd, input logic [WIDTH-1:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    task automatic drive_llu(input logic v, input wr_req_t req);
        llu_valid = v;
        llu_rd    = req.rd;
        llu_data  = req.data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) bank[i] = '0;
        rst = 1'b1;
        drive_wb(1'b0, '0, '0);
        drive_llu(1'b0, '0);
        issue_valid = 1'b0;
        issue_rd    = '0;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_rd      = '0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_regwrite", REGWRITE, 0);
        check("rst_adr", ADR_WR_REG, 0);
        check("rst_data", WR_DATA, 0);
        check("rst_drain", drain_req, 0);
        check("rst_llu_ready", llu_ready, 1);
        check("rst_hazard", hazard_stall, 0);

        // WB write, 1-cycle latency
        drive_wb(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        drive_wb(1'b0, '0, '0);
        check("wb_regwrite", REGWRITE, 1);
        check("wb_adr", ADR_WR_REG, 5);
        check("wb_data", WR_DATA, 32'hDEADBEEF);
        step();
        check("wb_idle_regwrite", REGWRITE, 0);
        check("bank_x5", bank[5], 32'hDEADBEEF);

        // Scoreboard hazard and LLU 2-cycle latency
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        issue_valid = 1'b0;
        issue_rd    = '0;
        dec_rs1     = 5'd7;
        #1;
        check("haz_rs1_pending", hazard_stall, 1);
        dec_rs1 = '0;
        dec_rd  = 5'd7;
        #1;
        check("haz_rd_pending", hazard_stall, 1);
        dec_rd  = '0;
        dec_rs1 = 5'd7;
        drive_llu(1'b1, '{rd: 5'd7, data: 32'h42});
        step();
        drive_llu(1'b0, '0);
        check("llu_enq_no_write", REGWRITE, 0);
        check("haz_still_pending", hazard_stall, 1);
        step();
        check("llu_regwrite", REGWRITE, 1);
        check("llu_adr", ADR_WR_REG, 7);
        check("llu_data", WR_DATA, 32'h42);
        step();
        check("haz_cleared", hazard_stall, 0);
        check("bank_x7", bank[7], 32'h42);
        dec_rs1 = '0;

        // Simultaneous WB and LLU: WB first, LLU next cycle
        drive_wb(1'b1, 5'd3, 32'h33);
        drive_llu(1'b1, '{rd: 5'd4, data: 32'h44});
        step();
        drive_wb(1'b0, '0, '0);
        drive_llu(1'b0, '0);
        check("both_first_adr", ADR_WR_REG, 3);
        check("both_first_data", WR_DATA, 32'h33);
        step();
        check("both_second_we", REGWRITE, 1);
        check("both_second_adr", ADR_WR_REG, 4);
        check("both_second_data", WR_DATA, 32'h44);

        // Starvation: WB every cycle with two LLU results queued
        drive_wb(1'b1, 5'd10, 32'hA0);
        drive_llu(1'b1, '{rd: 5'd12, data: 32'h1200});
        step();
        check("starve_c0_adr", ADR_WR_REG, 10);
        drive_wb(1'b1, 5'd11, 32'hA1);
        drive_llu(1'b1, '{rd: 5'd13, data: 32'h1300});
        step();
        drive_llu(1'b0, '0);
        check("fifo_full_ready", llu_ready, 0);
        check("starve_c1_adr", ADR_WR_REG, 11);
        drive_wb(1'b1, 5'd14, 32'hA2);
        step();
        check("starve_c2_drain", drain_req, 0);
        drive_wb(1'b1, 5'd15, 32'hA3);
        step();
        check("starve_c3_drain", drain_req, 0);
        drive_wb(1'b1, 5'd16, 32'hA4);
        step();
        check("starve_c4_drain", drain_req, 1);
        check("starve_c4_adr", ADR_WR_REG, 16);
        // Upstream ignores drain_req once: WB still wins, drain_req stays up
        drive_wb(1'b1, 5'd17, 32'hA5);
        step();
        check("starve_ignored_drain", drain_req, 1);
        check("starve_ignored_adr", ADR_WR_REG, 17);
        check("starve_ignored_ready", llu_ready, 0);
        drive_wb(1'b0, '0, '0);
        step();
        check("drain_head_we", REGWRITE, 1);
        check("drain_head_adr", ADR_WR_REG, 12);
        check("drain_head_data", WR_DATA, 32'h1200);
        check("drain_req_drop", drain_req, 0);
        check("drain_ready", llu_ready, 1);
        step();
        check("drain_second_adr", ADR_WR_REG, 13);
        check("drain_second_data", WR_DATA, 32'h1300);
        step();
        check("drain_idle_we", REGWRITE, 0);

        // wb_rd = 0 does not block a drain; x0 LLU entry consumes a slot silently
        drive_llu(1'b1, '{rd: 5'd9, data: 32'h99});
        step();
        check("x9_enq_no_write", REGWRITE, 0);
        drive_wb(1'b1, 5'd0, 32'hBAD);
        drive_llu(1'b1, '{rd: 5'd0, data: 32'h55});
        step();
        drive_wb(1'b0, '0, '0);
        drive_llu(1'b0, '0);
        check("wb0_drain_we", REGWRITE, 1);
        check("wb0_drain_adr", ADR_WR_REG, 9);
        check("wb0_drain_data", WR_DATA, 32'h99);
        step();
        check("x0_entry_no_write", REGWRITE, 0);
        check("x0_entry_adr_hold", ADR_WR_REG, 9);
        check("x0_entry_ready", llu_ready, 1);
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        step();
        issue_valid = 1'b0;
        #1;
        check("issue_x0_no_stall", hazard_stall, 0);

        // Async reset with two FIFO entries and a pending rd
        issue_valid = 1'b1;
        issue_rd    = 5'd22;
        drive_wb(1'b1, 5'd1, 32'h11);
        drive_llu(1'b1, '{rd: 5'd20, data: 32'h2000});
        step();
        issue_valid = 1'b0;
        issue_rd    = '0;
        drive_wb(1'b1, 5'd2, 32'h22);
        drive_llu(1'b1, '{rd: 5'd21, data: 32'h2100});
        step();
        drive_llu(1'b0, '0);
        dec_rs2 = 5'd22;
        #1;
        check("pre_rst_hazard", hazard_stall, 1);
        check("pre_rst_ready", llu_ready, 0);
        check("pre_rst_we", REGWRITE, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_we", REGWRITE, 0);
        check("mid_rst_adr", ADR_WR_REG, 0);
        check("mid_rst_data", WR_DATA, 0);
        check("mid_rst_ready", llu_ready, 1);
        check("mid_rst_hazard", hazard_stall, 0);
        check("mid_rst_drain", drain_req, 0);
        drive_wb(1'b0, '0, '0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_write", REGWRITE, 0);
        end
        check("post_rst_hazard", hazard_stall, 0);
        dec_rs2 = '0;

        // Final register bank contents
        check("bank_x0", bank[0], 0);
        check("bank_x3", bank[3], 32'h33);
        check("bank_x4", bank[4], 32'h44);
        check("bank_x9", bank[9], 32'h99);
        check("bank_x12", bank[12], 32'h1200);
        check("bank_x20_untouched", bank[20], 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
